add_seq_arbiter: RTL and testbench

ADD_SEQ_ARBITER -- requirements
Module: add_seq_arbiter

---
 rtl/add_seq_pkg.sv | 21 ++
 rtl/add_seq_arbiter_if.sv | 43 ++++
 rtl/add_slice.sv | 21 ++
 rtl/add_seq_arbiter.sv | 131 +++++++++++++
 tb/tb_add_seq_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/add_seq_pkg.sv
// Shared definitions for the sequential slice-adder arbiter: FSM state
// encodings, default geometry and a helper for sizing the slice index.
package add_seq_pkg;

    // Default adder slice width (bits added per cycle) and slices per word.
    localparam int N_DEF = 2;
    localparam int K_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that indexes k slices; never narrower than one bit,
    // so that k = 1 still yields a legal register.
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/add_seq_arbiter_if.sv
// Requester and result handshake bundle for add_seq_arbiter.
// master: the side issuing operand pairs and consuming results.
// slave:  the arbiter/adder itself.
interface add_seq_arbiter_if
    import add_seq_pkg::*;
#(
    parameter int W = N_DEF * K_DEF
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic [W-1:0] res_sum;
    logic         res_cout;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_id, res_sum, res_cout,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_id, res_sum, res_cout,
        input  res_ready
    );

endinterface

// File: rtl/add_slice.sv
// One N-bit slice of the ripple adder: a + b + cin, purely combinational.
module add_slice
    import add_seq_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] total;

    // Widen to N+1 bits so the top bit captures the slice carry.
    assign total = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign sum   = total[N-1:0];
    assign cout  = total[N];

endmodule

// File: rtl/add_seq_arbiter.sv
// Two-requester round-robin arbiter in front of a multi-cycle adder that
// processes one N-bit slice per clock, K slices per W = N*K bit word.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for a request; the only state that grants
//   ADD     | adding slice idx_q into sum_q, carry in carry_q
//   DONE    | result presented on res_*, held until res_ready
module add_seq_arbiter
    import add_seq_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    add_seq_arbiter_if.slave  bus
);

    localparam int W  = N * K;
    localparam int IW = idx_width(K);

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum_q;
    logic          carry_q;
    logic          id_q;
    logic          ptr_q;
    logic          valid_q;
    logic [IW-1:0] idx_q;

    logic          grant_id;
    logic          ready0;
    logic          ready1;
    logic          accept;
    logic [N-1:0]  a_slice;
    logic [N-1:0]  b_slice;
    logic [N-1:0]  slice_sum;
    logic          slice_cout;

    // Round-robin pick: a lone requester wins; on a tie the one not
    // granted last wins. With nobody valid the choice is irrelevant.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            grant_id = ~ptr_q;
        else
            grant_id = bus.req1_valid;
    end

    // Ready is offered only in IDLE and only to the granted, valid requester.
    always_comb begin
        ready0 = (state == ST_IDLE) && bus.req0_valid && !grant_id;
        ready1 = (state == ST_IDLE) && bus.req1_valid &&  grant_id;
        accept = ready0 || ready1;
    end

    // Select the operand slice currently being added.
    always_comb begin
        a_slice = a_q[int'(idx_q) * N +: N];
        b_slice = b_q[int'(idx_q) * N +: N];
    end

    add_slice #(.N(N)) u_slice (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Sequencer: capture on accept, ripple one slice per cycle, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b1;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_q     <= grant_id ? bus.req1_a : bus.req0_a;
                        b_q     <= grant_id ? bus.req1_b : bus.req0_b;
                        id_q    <= grant_id;
                        ptr_q   <= grant_id;
                        idx_q   <= '0;
                        carry_q <= 1'b0;
                        state   <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    sum_q[int'(idx_q) * N +: N] <= slice_sum;
                    carry_q <= slice_cout;
                    if (idx_q == IW'(K - 1)) begin
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    // The consume edge never doubles as an accept edge.
                    if (bus.res_ready) begin
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.res_valid  = valid_q;
    assign bus.res_id     = id_q;
    assign bus.res_sum    = sum_q;
    assign bus.res_cout   = carry_q;

endmodule

// File: tb/tb_add_seq_arbiter.sv
// Bench for add_seq_arbiter at N=2, K=4 (W=8): directed cases followed by
// randomized operations, checked against a transaction-level model
// (integer addition, round-robin pointer, fixed latency of K edges).
module tb_add_seq_arbiter;
    import add_seq_pkg::*;

    localparam int N = 2;
    localparam int K = 4;
    localparam int W = N * K;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ptr = 1;
    int   last_accept = 0;
    int   acc_first = 0;

    add_seq_arbiter_if #(.W(W)) bus ();

    add_seq_arbiter #(.N(N), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation: present requests, expect the model's grant,
    // follow it through K add cycles, hold DONE for 'stall' extra cycles,
    // then consume. Returns one cycle after the consume edge.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [7:0] a0, input logic [7:0] b0,
                          input logic [7:0] a1, input logic [7:0] b1,
                          input int stall, input bit wiggle);
        int g;
        logic [8:0] full;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_a = a0;
        bus.req0_b = b0;
        bus.req1_a = a1;
        bus.req1_b = b1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        g = (v0 && v1) ? ((ptr == 0) ? 1 : 0) : (v0 ? 0 : 1);
        chk("grant_ready0", bus.req0_ready, (v0 && g == 0));
        chk("grant_ready1", bus.req1_ready, (v1 && g == 1));
        @(posedge clk);
        #1;
        last_accept = cyc;
        ptr = g;
        full = (g == 1) ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
        // Consumed request goes away; scramble its operands to prove capture.
        if (g == 0) begin
            bus.req0_valid = 1'b0;
            bus.req0_a = 8'($urandom);
            bus.req0_b = 8'($urandom);
        end else begin
            bus.req1_valid = 1'b0;
            bus.req1_a = 8'($urandom);
            bus.req1_b = 8'($urandom);
        end
        for (int i = 0; i < K; i++) begin
            @(negedge clk);
            chk("busy_res_valid", bus.res_valid, 1'b0);
            chk("busy_ready0", bus.req0_ready, 1'b0);
            chk("busy_ready1", bus.req1_ready, 1'b0);
            if (wiggle) begin
                if (g == 0) bus.req1_valid = 1'($urandom_range(0, 1));
                else        bus.req0_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
        end
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            chk("done_res_valid", bus.res_valid, 1'b1);
            chk("done_res_sum", bus.res_sum, full[7:0]);
            chk("done_res_cout", bus.res_cout, full[8]);
            chk("done_res_id", bus.res_id, g);
            chk("done_ready0", bus.req0_ready, 1'b0);
            chk("done_ready1", bus.req1_ready, 1'b0);
            if (s == stall) bus.res_ready = 1'b1;
            else @(posedge clk);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        chk("consumed_res_valid", bus.res_valid, 1'b0);
    endtask

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a = '0;
        bus.req0_b = '0;
        bus.req1_a = '0;
        bus.req1_b = '0;
        bus.res_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_res_id", bus.res_id, 1'b0);
        chk("rst_res_sum", bus.res_sum, 8'h00);
        chk("rst_res_cout", bus.res_cout, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin tie from reset: req0 first, req1 exactly K+2 later.
        run_op(1'b1, 1'b1, 8'h10, 8'h01, 8'h20, 8'h02, 0, 1'b0);
        acc_first = last_accept;
        run_op(1'b0, 1'b1, 8'h10, 8'h01, 8'h20, 8'h02, 0, 1'b0);
        chk("rr_accept_spacing", last_accept - acc_first, K + 2);

        // Basic add on requester 0.
        run_op(1'b1, 1'b0, 8'h2D, 8'h3C, 8'h00, 8'h00, 0, 1'b0);
        // Full carry ripple on requester 1.
        run_op(1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h01, 0, 1'b0);
        // Backpressure: result held for 5 extra cycles, other side waiting.
        run_op(1'b1, 1'b1, 8'hA5, 8'h7B, 8'h33, 8'h44, 5, 1'b0);

        // Reset in the middle of ADD (slice index 2).
        bus.req1_valid = 1'b1;
        bus.req1_a = 8'h37;
        bus.req1_b = 8'h25;
        bus.req0_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", bus.res_valid, 1'b0);
        chk("midrst_res_sum", bus.res_sum, 8'h00);
        chk("midrst_res_cout", bus.res_cout, 1'b0);
        chk("midrst_res_id", bus.res_id, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr = 1;
        for (int i = 0; i < K + 2; i++) begin
            @(negedge clk);
            chk("postrst_no_result", bus.res_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        run_op(1'b1, 1'b0, 8'h80, 8'h80, 8'h00, 8'h00, 0, 1'b0);

        // Randomized operations against the model.
        for (int n = 0; n < 24; n++) begin
            bit rv0, rv1;
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (!rv0 && !rv1) begin
                if ($urandom_range(0, 1) == 0) rv0 = 1'b1;
                else rv1 = 1'b1;
            end
            run_op(rv0, rv1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
